instr_loader: RTL
=================

Name: instr_loader

Overview:
- Upstream stage of the single-cycle cpu: streams a program from a host word interface into the instruction memory.
- Drives the cpu's initialize, instruction_initialize_data and instruction_initialize_address inputs.
- Holds the cpu in reset through the load and for a fixed settle window after it, then releases the cpu to run from BASE_ADDR.
- Supports repeated reloads without a global reset.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address written by the first program word; also the address the cpu fetches after release.
- MAX_WORDS, 64, capacity of instruction memory in 32-bit words; writes beyond it are refused.
- RST_HOLD, 2, cycles cpu_rst stays high after the last write (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a (re)load; sampled in IDLE and RUN only.
- in_valid  input  1  host word valid.
- in_data  input  32  host instruction word.
- in_last  input  1  qualifies in_data as the final program word.
- in_ready  output  1  loader accepts in_data this cycle.
- initialize  output  1  instruction-memory write strobe to the cpu.
- instruction_initialize_data  output  32  word to write.
- instruction_initialize_address  output  32  byte address to write.
- cpu_rst  output  1  reset to the cpu's rst input.
- done  output  1  program loaded, cpu running.
- error  output  1  overflow: more than MAX_WORDS offered without in_last.
- word_count  output  16  words accepted in the current load.

Behaviour:
- One clock; synchronous active-high reset. rst has priority over every other input.
- Reset values:
  - State IDLE.
  - initialize=0, instruction_initialize_data=0, instruction_initialize_address=BASE_ADDR.
  - cpu_rst=1, done=0, error=0, word_count=0, in_ready=0.
- States: IDLE, LOAD, FLUSH, RUN.
- IDLE:
  - cpu_rst=1, in_ready=0.
  - start=1 -> LOAD next cycle; word_count cleared, error cleared, write pointer set to BASE_ADDR.
- LOAD:
  - cpu_rst=1.
  - in_ready = (word_count < MAX_WORDS), decoded combinationally from state and count.
  - Transfer happens when in_valid && in_ready at edge t.
  - In cycle t+1: initialize=1, instruction_initialize_data=in_data, instruction_initialize_address=pointer. Pointer += 4 and word_count += 1 at the same edge.
  - initialize is a one-cycle pulse per accepted word. Back-to-back transfers give consecutive pulses with addresses BASE_ADDR, +4, +8, ...
  - No transfer -> initialize=0; data and address hold their last values.
  - Transfer with in_last=1 -> FLUSH next cycle. The final write pulse occurs in the first FLUSH cycle.
  - in_valid=1 while word_count==MAX_WORDS -> word not written, error=1, -> IDLE. cpu stays in reset; error is sticky until the next start or rst.
  - start is ignored in LOAD.
- FLUSH:
  - cpu_rst=1, in_ready=0.
  - Counts exactly RST_HOLD cycles, then -> RUN.
  - start is ignored.
- RUN:
  - cpu_rst=0, done=1, in_ready=0.
  - start=1 -> LOAD next cycle: done=0, cpu_rst=1 in that cycle, count and pointer reset, memory overwritten from BASE_ADDR.
- Latency:
  - start at edge t -> in_ready=1 in cycle t+1.
  - Last transfer at edge t -> cpu_rst falls and done rises in cycle t+RST_HOLD+1.
- Pointer arithmetic is 32-bit unsigned with natural wrap. It is never reached with legal parameters (BASE_ADDR + 4*MAX_WORDS < 2^32).
- rst mid-LOAD or mid-FLUSH:
  - Immediately returns to IDLE with reset values.
  - No initialize pulse in the cycle after rst, even if a transfer coincided with rst.
- in_valid outside LOAD: ignored, no write, no error.
- word_count saturates at MAX_WORDS and never wraps.

Test Plan:
- Basic load (BASE_ADDR=0, RST_HOLD=2):
  - Stimulus: rst, start, then 3 back-to-back words 0x2001_0005, 0x2002_0003, 0x0022_1820 (last on 3rd).
  - Required: initialize pulses on 3 consecutive cycles at addresses 0x0, 0x4, 0x8 with matching data; word_count=3.
  - Required: cpu_rst falls and done rises exactly 3 cycles after the last transfer edge.
- Gapped valid:
  - Stimulus: in_valid toggling 1,0,0,1(last).
  - Required: exactly 2 initialize pulses at 0x0 and 0x4; no pulse in gap cycles; data/address hold between pulses.
- Overflow (MAX_WORDS=4):
  - Stimulus: 5 words, none with in_last.
  - Required: 4 writes at 0x0..0xC; in_ready=0 on the 5th; error=1; state IDLE; cpu_rst stays 1; done stays 0; no 5th pulse.
- Reload from RUN:
  - Stimulus: after a 3-word load, assert start, then load 2 words 0xAAAA_0001, 0xBBBB_0002 (last).
  - Required: done=0 and cpu_rst=1 the cycle after start; writes at 0x0 and 0x4; word_count=2; done=1 after RST_HOLD.
- Reset mid-load:
  - Stimulus: assert rst on the same edge as the 2nd transfer.
  - Required: next cycle initialize=0, address=BASE_ADDR, word_count=0, cpu_rst=1, error=0.
  - Required: subsequent in_valid is ignored until start.
- Ignored start and valid:
  - Stimulus: pulse start during LOAD and FLUSH; drive in_valid during FLUSH and RUN.
  - Required: no state change; word_count unchanged; no initialize pulses.

Source files
------------

// File: rtl/instr_loader.sv
// Program loader: streams host words into the cpu's instruction memory while
// holding the cpu in reset, then releases it to run from BASE_ADDR.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned RST_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [15:0] MAX_CNT   = 16'(MAX_WORDS);
  localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD - 1);

  state_t      state;
  logic [31:0] wr_ptr;
  logic [7:0]  hold_cnt;
  logic        xfer;

  // Handshake: a word transfers at a rising edge where in_valid && in_ready.
  // in_ready is combinational from state and count, so it drops the cycle
  // the memory is full and never depends on in_valid.
  assign in_ready  = (state == LOAD) && (word_count < MAX_CNT);
  assign xfer      = in_valid && in_ready;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                          <= IDLE;
      initialize                     <= 1'b0;
      instruction_initialize_data    <= 32'd0;
      instruction_initialize_address <= BASE_ADDR;
      cpu_rst                        <= 1'b1;
      done                           <= 1'b0;
      error                          <= 1'b0;
      word_count                     <= 16'd0;
      wr_ptr                         <= BASE_ADDR;
      hold_cnt                       <= 8'd0;
    end else begin
      initialize <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            word_count <= 16'd0;
            error      <= 1'b0;
            wr_ptr     <= BASE_ADDR;
          end
        end
        LOAD: begin
          if (xfer) begin
            initialize                     <= 1'b1;
            instruction_initialize_data    <= in_data;
            instruction_initialize_address <= wr_ptr;
            wr_ptr                         <= wr_ptr + 32'd4;
            word_count                     <= word_count + 16'd1;
            if (in_last) begin
              state    <= FLUSH;
              hold_cnt <= 8'd0;
            end
          end else if (in_valid) begin
            // Offered while full: refuse the word and abandon the load.
            error <= 1'b1;
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN: begin
          if (start) begin
            state      <= LOAD;
            done       <= 1'b0;
            cpu_rst    <= 1'b1;
            word_count <= 16'd0;
            error      <= 1'b0;
            wr_ptr     <= BASE_ADDR;
          end
        end
      endcase
    end
  end

endmodule
